// File: rtl/contador_dest_if.sv
// contador_dest_if: bus bundle for the egress traffic counter.
//   FIFO side : D0/D1 empty flags and read data in, D0_rd/D1_rd pop strobes out.
//   Control   : enable (drain/count), clear (zero counters while holding), busy, misroute.
//   Readback  : req/idx in, valid/data_out out (one-cycle latency).
// The counter block connects through the slave modport; the environment drives
// it through the master modport.
interface contador_dest_if #(
    parameter int unsigned BW = 6,
    parameter int unsigned CW = 5
);
    logic          enable;
    logic          clear;
    logic          D0_empty;
    logic          D1_empty;
    logic [BW-1:0] D0_data_out;
    logic [BW-1:0] D1_data_out;
    logic          D0_rd;
    logic          D1_rd;
    logic          req;
    logic [1:0]    idx;
    logic          valid;
    logic [CW-1:0] data_out;
    logic          misroute;
    logic          busy;

    modport slave (
        input  enable, clear, D0_empty, D1_empty, D0_data_out, D1_data_out, req, idx,
        output D0_rd, D1_rd, valid, data_out, misroute, busy
    );

    modport master (
        output enable, clear, D0_empty, D1_empty, D0_data_out, D1_data_out, req, idx,
        input  D0_rd, D1_rd, valid, data_out, misroute, busy
    );
endinterface

// File: rtl/contador_dest.sv
// contador_dest: drains the D0/D1 destination FIFOs and counts words per
// {port, vc}. Words whose destination bit disagrees with the port they came
// from set a sticky misroute flag. After enable drops the block flushes the
// last in-flight pops, then holds the counts for readback via req/idx.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : contador_dest_if slave (FIFO pops, control, readback)
module contador_dest #(
    parameter int unsigned BW = 6,
    parameter int unsigned CW = 5
) (
    input logic             clk,
    input logic             reset,
    contador_dest_if.slave  bus
);

    typedef enum logic [1:0] {StOff, StRun, StFlush, StHold} state_e;

    state_e        state_q, state_d;
    logic [1:0]    rd_q, rd_d;     // pop strobes, bit p = port p
    logic [1:0]    vld_q, vld_d;   // FIFO read data valid this cycle
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic          misroute_q, misroute_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] data_out_q, data_out_d;
    logic          busy_q, busy_d;

    logic [1:0]    empty;
    logic [1:0]    sel0, sel1;
    logic          unused_data;

    assign empty = {bus.D1_empty, bus.D0_empty};
    // Counter index is {port, vc}
    assign sel0  = {1'b0, bus.D0_data_out[BW-1]};
    assign sel1  = {1'b1, bus.D1_data_out[BW-1]};
    // Payload bits are not inspected
    assign unused_data = ^{bus.D0_data_out[BW-3:0], bus.D1_data_out[BW-3:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        misroute_d = misroute_q;

        case (state_q)
            StOff:   if (bus.enable) state_d = StRun;
            StRun:   if (!bus.enable) state_d = StFlush;
            StFlush: state_d = StHold;
            StHold:  if (bus.enable) state_d = StRun;
            default: state_d = StOff;
        endcase

        // Pop strobes are registered; a pop is only scheduled into a cycle that
        // will be RUN, and never two cycles in a row so the FIFO empty flag has
        // caught up before the next decision.
        for (int p = 0; p < 2; p++) begin
            rd_d[p] = (state_d == StRun) && !empty[p] && !rd_q[p];
        end
        vld_d = rd_q;

        if (state_q == StHold && bus.clear) begin
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = '0;
            end
            misroute_d = 1'b0;
        end else begin
            // Ports feed disjoint counters, so both may increment together
            if (vld_q[0]) begin
                cnt_d[sel0] = cnt_q[sel0] + CW'(1);
                if (bus.D0_data_out[BW-2] != 1'b0) misroute_d = 1'b1;
            end
            if (vld_q[1]) begin
                cnt_d[sel1] = cnt_q[sel1] + CW'(1);
                if (bus.D1_data_out[BW-2] != 1'b1) misroute_d = 1'b1;
            end
        end

        valid_d    = (state_q == StHold) && bus.req;
        data_out_d = valid_d ? cnt_q[bus.idx] : data_out_q;
        busy_d     = (state_d == StRun) || (state_d == StFlush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StOff;
            rd_q       <= '0;
            vld_q      <= '0;
            misroute_q <= 1'b0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            vld_q      <= vld_d;
            misroute_q <= misroute_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.D0_rd    = rd_q[0];
    assign bus.D1_rd    = rd_q[1];
    assign bus.valid    = valid_q;
    assign bus.data_out = data_out_q;
    assign bus.misroute = misroute_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_contador_dest.sv
// tb_contador_dest: directed bench for contador_dest with a small FIFO model
// on each port (read data registered one cycle after the pop strobe).
module tb_contador_dest;
    localparam int unsigned BW = 6;
    localparam int unsigned CW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    contador_dest_if #(.BW(BW), .CW(CW)) bus ();

    contador_dest #(.BW(BW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // FIFO models
    logic [BW-1:0] mem0 [128];
    logic [BW-1:0] mem1 [128];
    int            wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    logic          force_ne = 1'b0;
    logic [BW-1:0] q0 = '0, q1 = '0;

    assign bus.D0_empty    = (rd0 == wr0) && !force_ne;
    assign bus.D1_empty    = (rd1 == wr1) && !force_ne;
    assign bus.D0_data_out = q0;
    assign bus.D1_data_out = q1;

    always @(posedge clk) begin
        if (bus.D0_rd) begin
            q0  <= mem0[rd0[6:0]];
            rd0 <= rd0 + 1;
        end
        if (bus.D1_rd) begin
            q1  <= mem1[rd1[6:0]];
            rd1 <= rd1 + 1;
        end
    end

    // Pop strobe must never be high in two consecutive cycles
    int   b2b_viol = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        if (!reset && ((bus.D0_rd && prev0) || (bus.D1_rd && prev1))) b2b_viol <= b2b_viol + 1;
        prev0 <= bus.D0_rd;
        prev1 <= bus.D1_rd;
    end

    int errors = 0;
    int checks = 0;

    task automatic push0(input logic [BW-1:0] w);
        mem0[wr0[6:0]] = w;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [BW-1:0] w);
        mem1[wr1[6:0]] = w;
        wr1 = wr1 + 1;
    endtask

    // Enable until both FIFOs are empty, drop enable, wait for busy to clear.
    task automatic drain(input int budget, output bit ok);
        bit emptied;
        bit idle;
        emptied = 1'b0;
        idle = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.D0_empty && bus.D1_empty) begin
                emptied = 1'b1;
                break;
            end
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle = 1'b1;
                break;
            end
        end
        ok = emptied && idle;
    endtask

    task automatic do_read(input logic [1:0] i, output logic v, output logic [CW-1:0] d);
        @(negedge clk);
        bus.req = 1'b1;
        bus.idx = i;
        @(negedge clk);
        bus.req = 1'b0;
        v = bus.valid;
        d = bus.data_out;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1;
        bus.clear  = 1'b0;
        bus.req    = 1'b0;
        bus.idx    = 2'd0;
        force_ne   = 1'b1;
        reset      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.D0_rd, bus.D1_rd, bus.valid, bus.data_out, bus.misroute, bus.busy} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: rd0=%b rd1=%b valid=%b data=%0d mis=%b busy=%b, required all 0",
                         i, bus.D0_rd, bus.D1_rd, bus.valid, bus.data_out, bus.misroute, bus.busy);
            end
        end
        reset      = 1'b0;
        bus.enable = 1'b0;
        force_ne   = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.D0_rd !== 1'b0) begin
            errors++;
            $display("FAIL off_idle: busy=%b rd0=%b, required 0 0", bus.busy, bus.D0_rd);
        end
    endtask

    task automatic test_count();
        bit ok;
        logic v;
        logic [CW-1:0] d;
        logic [CW-1:0] exp [4];
        exp[0] = 5'd3; exp[1] = 5'd2; exp[2] = 5'd4; exp[3] = 5'd0;
        for (int i = 0; i < 3; i++) push0(6'h00);
        for (int i = 0; i < 2; i++) push0(6'h20);
        for (int i = 0; i < 4; i++) push1(6'h10);
        drain(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL count_drain: drain/flush did not complete, required completion");
        end
        checks++;
        if (bus.misroute !== 1'b0) begin
            errors++;
            $display("FAIL count_misroute: misroute=%b, required 0", bus.misroute);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i), v, d);
            checks++;
            if (v !== 1'b1 || d !== exp[i]) begin
                errors++;
                $display("FAIL count_read idx %0d: valid=%b data=%0d, required valid=1 data=%0d",
                         i, v, d, exp[i]);
            end
        end
    endtask

    task automatic test_misroute();
        bit ok;
        logic v;
        logic [CW-1:0] d;
        push0(6'h10);
        drain(20, ok);
        checks++;
        if (!ok || bus.misroute !== 1'b1) begin
            errors++;
            $display("FAIL misroute_set: drained=%b misroute=%b, required 1 1", ok, bus.misroute);
        end
        do_read(2'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 5'd4) begin
            errors++;
            $display("FAIL misroute_count: valid=%b data=%0d, required valid=1 data=4", v, d);
        end
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checks++;
        if (bus.misroute !== 1'b0) begin
            errors++;
            $display("FAIL clear_misroute: misroute=%b, required 0", bus.misroute);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(2'(i), v, d);
            checks++;
            if (v !== 1'b1 || d !== 5'd0) begin
                errors++;
                $display("FAIL clear_read idx %0d: valid=%b data=%0d, required valid=1 data=0",
                         i, v, d);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic v;
        logic [CW-1:0] d;
        for (int i = 0; i < 33; i++) push0(6'h00);
        drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap_drain: drain/flush did not complete, required completion");
        end
        do_read(2'd2, v, d);
        checks++;
        if (v !== 1'b1 || d !== 5'd0) begin
            errors++;
            $display("FAIL wrap_idx2: valid=%b data=%0d, required valid=1 data=0", v, d);
        end
        do_read(2'd0, v, d);
        checks++;
        if (v !== 1'b1 || d !== 5'd1) begin
            errors++;
            $display("FAIL wrap_idx0: valid=%b data=%0d, required valid=1 data=1", v, d);
        end
    endtask

    task automatic test_last_pop();
        logic v;
        logic [CW-1:0] d;
        push0(6'h20);
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        // First RUN cycle: pop is issued here and enable falls now
        checks++;
        if (bus.D0_rd !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL last_pop_rd: rd0=%b busy=%b, required 1 1", bus.D0_rd, bus.busy);
        end
        bus.enable = 1'b0;
        bus.req    = 1'b1;
        bus.idx    = 2'd1;
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0 || bus.D0_rd !== 1'b0) begin
            errors++;
            $display("FAIL req_in_run: valid=%b rd0=%b, required 0 0", bus.valid, bus.D0_rd);
        end
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0 || bus.data_out !== 5'd1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL req_in_flush: valid=%b data=%0d busy=%b, required 0 1 0",
                     bus.valid, bus.data_out, bus.busy);
        end
        bus.req = 1'b0;
        do_read(2'd1, v, d);
        checks++;
        if (v !== 1'b1 || d !== 5'd1) begin
            errors++;
            $display("FAIL last_pop_count: valid=%b data=%0d, required valid=1 data=1", v, d);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [1:0]    idx_seq [3];
        logic [CW-1:0] exp_seq [3];
        idx_seq[0] = 2'd3; idx_seq[1] = 2'd0; idx_seq[2] = 2'd1;
        exp_seq[0] = 5'd3; exp_seq[1] = 5'd1; exp_seq[2] = 5'd2;
        for (int i = 0; i < 3; i++) push1(6'h30);
        push0(6'h20);
        drain(30, ok);
        checks++;
        if (!ok || bus.misroute !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: drained=%b misroute=%b, required 1 0", ok, bus.misroute);
        end
        @(negedge clk);
        bus.req = 1'b1;
        bus.idx = idx_seq[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) bus.idx = idx_seq[i+1];
            else       bus.req = 1'b0;
            checks++;
            if (bus.valid !== 1'b1 || bus.data_out !== exp_seq[i]) begin
                errors++;
                $display("FAIL b2b_read %0d: valid=%b data=%0d, required valid=1 data=%0d",
                         i, bus.valid, bus.data_out, exp_seq[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b, required 0", bus.valid);
        end
        checks++;
        if (b2b_viol !== 0) begin
            errors++;
            $display("FAIL pop_spacing: consecutive pops=%0d, required 0", b2b_viol);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_misroute();
        test_wrap();
        test_last_pop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_dest.md
# contador_dest

Traffic-counter and drain stage at the egress side of the PCIe QoS fabric. It pops words from the D0 and D1 destination FIFOs whenever they are non-empty. It classifies each popped word by port and virtual channel into four counters, and flags words that arrived on the wrong destination port. Once traffic stops, the bench or system reads the counts through a request/valid handshake and compares them against what was injected at Main.

## Interface
- BW, 6, data word width; bit BW-1 = VC id, bit BW-2 = destination id
- CW, 5, counter width

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- enable  in  1  1 = drain and count; 0 = stop (flush then hold)
- clear  in  1  zero all counters; honoured in HOLD only
- D0_empty  in  1  D0 FIFO empty flag
- D1_empty  in  1  D1 FIFO empty flag
- D0_data_out  in  BW  D0 FIFO read data, valid the cycle after D0_rd
- D1_data_out  in  BW  D1 FIFO read data, valid the cycle after D1_rd
- D0_rd  out  1  D0 pop strobe
- D1_rd  out  1  D1 pop strobe
- req  in  1  count read request
- idx  in  2  counter select: {port, vc}; 0=D0/VC0, 1=D0/VC1, 2=D1/VC0, 3=D1/VC1
- valid  out  1  data_out valid, one-cycle pulse
- data_out  out  CW  selected counter value
- misroute  out  1  sticky: a word's dest bit disagreed with its port
- busy  out  1  1 in RUN or FLUSH

## Operation
- FSM states: OFF, RUN, FLUSH, HOLD. Reset → OFF.
- OFF: no pops, counters 0. enable=1 → RUN.
- RUN:
  - Per port p: Dp_rd = !Dp_empty & !Dp_rd_q, where Dp_rd_q is Dp_rd registered. This gives at most one pop every two cycles per port, so the pop never races the FIFO empty update.
  - vld_p = Dp_rd_q. The word is sampled while vld_p=1.
  - enable=0 → FLUSH. No new pops are issued in the transition cycle.
- FLUSH: exactly one cycle. Any vld_p from a pop issued in the last RUN cycle is still counted. Next state HOLD.
- HOLD:
  - No pops; counters frozen.
  - clear=1 zeroes all counters and misroute.
  - enable=1 → RUN. Counters continue from their held values.
  - clear and enable high together: clear applies and the FSM moves to RUN.
- Counting:
  - On vld_p, counter {p, word[BW-1]} increments by 1, modulo 2^CW. The counter wraps; it does not saturate.
  - D0 and D1 feed disjoint counters, so simultaneous vld_0 and vld_1 both increment.
- Misroute: on vld_p with word[BW-2] != p, misroute is set to 1. It stays set until reset or clear. The word is still counted under its port.
- Read handshake:
  - req sampled in HOLD only. Next cycle: valid=1, data_out=counter[idx as sampled].
  - req held high in HOLD returns one result per cycle, pipelined.
  - req in any other state is ignored: valid stays 0, data_out holds.
- Reset mid-operation: all outputs and state return to reset values on the next edge. An in-flight vld is discarded.

## Timing
- Reset values: D0_rd=0, D1_rd=0, valid=0, data_out=0, misroute=0, busy=0, all counters 0, state OFF.
- Pop to count latency: Dp_rd at cycle t, data sampled at t+1, counter updated at edge t+2.
- Read latency: 1 cycle from req to valid.
- enable falling at cycle t: HOLD reached by t+2. Counts are final once busy=0.
- Sustained throughput: one word per port per 2 cycles.
- D0_rd and D1_rd are registered outputs: no combinational path from the empty flags.

## Test plan
- Reset with enable=1 and D0_empty=0 held → D0_rd, D1_rd, valid, data_out, misroute all 0 for every reset cycle; state OFF.
- Inject 3 words to D0 (vc0, 0x00), 2 to D0 (vc1, 0x20), 4 to D1 (vc0, 0x10), 0 to D1 vc1. Drop enable, then read idx 0..3 → 3, 2, 4, 0; misroute=0; D0_rd never high in two consecutive cycles.
- A word 0x10 (dest=1) presented on D0 → misroute=1, counter idx 0 incremented. clear in HOLD → misroute=0 and all counters 0.
- 33 words on D0 vc0 with CW=5 → counter idx 0 reads 1 (wrap).
- Pop issued in the last RUN cycle before enable falls → that word is counted; req during RUN or FLUSH → no valid pulse.
- Back-to-back req idx 3,0,1 in HOLD → valid high for 3 consecutive cycles with the matching counts in order.
